// File: rtl/tx_pkg.sv
// Constants and state encoding shared by the serial transmit and receive sides.
package tx_pkg;
  localparam int PACKET_W   = 55;
  localparam int FRAME_BITS = 58;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
endpackage

// File: rtl/tx_shift.sv
// Packet shift register: parallel load, shift right toward lsb, parity latched at load.
module tx_shift
  import tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [PACKET_W-1:0] din,
  output logic                lsb,
  output logic                parity
);
  logic [PACKET_W-1:0] sh_q, sh_d;
  logic                par_q, par_d;

  always_comb begin
    sh_d  = sh_q;
    par_d = par_q;
    if (load) begin
      sh_d  = din;
      par_d = ^din;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[PACKET_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      par_q <= par_d;
    end
  end

  assign lsb    = sh_q[0];
  assign parity = par_q;
endmodule

// File: rtl/transmitter.sv
// Serial frame transmitter: start, 55 data bits LSB first, even parity, stop.
module transmitter
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                Clk_S,
  input  logic                Rst,
  input  logic                TX_Data_Valid,
  input  logic [PACKET_W-1:0] TX_Data,
  output logic                TX_Ready,
  output logic                S_data,
  output logic                TX_Busy
);
  localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
  localparam logic [5:0] LAST_BIT = 6'(PACKET_W - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] clk_cnt_q, clk_cnt_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       s_data_q, s_data_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       load, shift, sh_lsb, sh_par, bit_done;

  tx_shift u_shift (
    .clk   (Clk_S),
    .rst   (Rst),
    .load  (load),
    .shift (shift),
    .din   (TX_Data),
    .lsb   (sh_lsb),
    .parity(sh_par)
  );

  assign bit_done = (clk_cnt_q == LAST_CLK);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_done ? 8'd0 : clk_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    s_data_d  = s_data_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        s_data_d  = IDLE_LVL;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        // ready_q gates acceptance so the first cycle after reset never accepts
        if (TX_Data_Valid && ready_q) begin
          load     = 1'b1;
          state_d  = START;
          s_data_d = START_LVL;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: if (bit_done) begin
        state_d   = DATA;
        s_data_d  = sh_lsb;
        shift     = 1'b1;
        bit_cnt_d = '0;
      end
      DATA: if (bit_done) begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = PARITY;
          s_data_d  = sh_par;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          s_data_d  = sh_lsb;
          shift     = 1'b1;
        end
      end
      PARITY: if (bit_done) begin
        state_d  = STOP;
        s_data_d = STOP_LVL;
      end
      STOP: if (bit_done) begin
        state_d  = IDLE;
        s_data_d = IDLE_LVL;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        s_data_d  = IDLE_LVL;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      s_data_q  <= IDLE_LVL;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      s_data_q  <= s_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_Ready = ready_q;
  assign S_data   = s_data_q;
  assign TX_Busy  = busy_q;
endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, giving Clk_S cycles per serial bit; legal range 1..255.
REQ-002 SHALL have port Clk_S, input, 1, sole clock; all flops update on its rising edge.
REQ-003 SHALL have port Rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port TX_Data_Valid, input, 1, upstream asserts when TX_Data holds a packet to send.
REQ-005 SHALL have port TX_Data, input, 55, packet to serialize.
REQ-006 SHALL have port TX_Ready, output, 1, registered; high only when the block can accept a packet.
REQ-007 SHALL have port S_data, output, 1, registered serial line; idles high.
REQ-008 SHALL have port TX_Busy, output, 1, registered; high while a frame is on the line.

Function
REQ-009 SHALL send frames of 58 bits in order: start (0), TX_Data[0]..TX_Data[54] (LSB first), even parity (XOR of the 55 data bits), stop (1).
REQ-010 SHALL hold each bit on S_data for exactly CLKS_PER_BIT cycles; frame length = 58*CLKS_PER_BIT cycles.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: S_data=1, TX_Ready=1, TX_Busy=0; on an edge with TX_Data_Valid=1 -> capture TX_Data into the shift register, go to START.
REQ-013 START -> DATA after CLKS_PER_BIT cycles; DATA -> PARITY after 55 bit periods; PARITY -> STOP after one bit period; STOP -> IDLE after one bit period.
REQ-014 Acceptance: the transfer occurs on the edge where TX_Data_Valid=1 and TX_Ready=1; the start bit SHALL appear on S_data in the following cycle (latency 1), with TX_Ready=0 and TX_Busy=1 from that cycle.
REQ-015 TX_Data and TX_Data_Valid SHALL be ignored outside IDLE; the captured packet is immune to later input changes.
REQ-016 TX_Data_Valid low in IDLE: remain IDLE, line high indefinitely.
REQ-017 Back-to-back: TX_Ready SHALL return high in the cycle after the stop bit's last cycle; with TX_Data_Valid held high, consecutive start bits SHALL be exactly 58*CLKS_PER_BIT+1 cycles apart.
REQ-018 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap, with no glitch or extra cycle at wrap; the bit counter SHALL count 0..54 in DATA and clear on leaving DATA.
REQ-019 Parity SHALL be computed from the captured packet, not from live TX_Data.
REQ-020 Unused state encodings SHALL return to IDLE on the next edge with S_data=1.

Reset
REQ-021 On an edge with Rst=1: state=IDLE, S_data=1, TX_Ready=0, TX_Busy=0, counters=0, shift register=0.
REQ-022 TX_Ready SHALL rise in the first cycle after Rst deasserts.
REQ-023 Reset during a frame SHALL abort it: line high on the next edge, with no stop bit or remaining bits sent.

Structure
REQ-024 Package tx_pkg SHALL hold PACKET_W=55, FRAME_BITS=58, the state enumeration, and START_LVL=0/STOP_LVL=1/IDLE_LVL=1 constants, all shared with the receive side.
REQ-025 One sub-module, tx_shift (55-bit load/shift-right register with parity output), SHALL be instantiated; the FSM and counters live in transmitter.

Verification
REQ-026 CLKS_PER_BIT=4, TX_Data=55'h0 accepted -> S_data: 4 cycles 0, 220 cycles 0, parity 0 for 4, stop 1 for 4; TX_Ready low for 232 cycles.
REQ-027 TX_Data=all 55 ones -> start 0, 220 cycles 1, parity 1, stop 1.
REQ-028 TX_Data=55'h1, with TX_Data changed to 55'h2 during DATA -> first data bit 1, remaining 54 bits 0, parity 1 (change ignored).
REQ-029 TX_Data_Valid held high with two packets -> start bits 233 cycles apart; TX_Ready high for exactly 1 cycle between frames.
REQ-030 Rst=1 asserted during data bit 20 -> S_data=1 next cycle; TX_Ready=0 while Rst=1, then 1 in the first cycle after Rst deasserts; a new frame then transmits correctly.
REQ-031 CLKS_PER_BIT=1, TX_Data=55'h2A -> 58-cycle frame matching REQ-009 bit by bit.
